// File: rtl/spi_rdid_responder_if.sv
// +------------------------------------------------------------------+
// | spi_rdid_responder_if : four-wire SPI bus plus MISO drive enable |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface spi_rdid_responder_if;
   logic SPICLK;
   logic chip_select;
   logic SPIMOSI;
   logic SPIMISO;
   logic miso_en;

   modport master (
      output SPICLK,
      output chip_select,
      output SPIMOSI,
      input  SPIMISO,
      input  miso_en
   );

   modport slave (
      input  SPICLK,
      input  chip_select,
      input  SPIMOSI,
      output SPIMISO,
      output miso_en
   );
endinterface

`default_nettype wire

// File: rtl/spi_rdid_responder.sv
// +------------------------------------------------------------------+
// | spi_rdid_responder : oversampled mode-0 SPI slave answering RDID |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_rdid_responder #(
   parameter logic [7:0] MANUF_ID    = 8'h20,
   parameter logic [7:0] MEM_TYPE    = 8'h20,
   parameter logic [7:0] MEM_CAP     = 8'h16,
   parameter logic [7:0] RDID_CMD    = 8'h9F,
   parameter int         SYNC_STAGES = 2
) (
   input  wire logic             clk,
   input  wire logic             reset,
   spi_rdid_responder_if.slave   bus,
   output logic [7:0]            cmd_byte,
   output logic                  cmd_valid,
   output logic                  rdid_done,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      RESP   = 2'd2,
      IGNORE = 2'd3
   } state_t;

   localparam logic [23:0] ID_WORD = {MANUF_ID, MEM_TYPE, MEM_CAP};

   logic sclk_s;
   logic cs_s;
   logic mosi_s;

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [SYNC_STAGES-1:0] sclk_q;
         logic [SYNC_STAGES-1:0] cs_q;
         logic [SYNC_STAGES-1:0] mosi_q;

         always_ff @(posedge clk) begin
            if (!reset) begin
               sclk_q <= '0;
               cs_q   <= '1;
               mosi_q <= '0;
            end else begin
               sclk_q[0] <= bus.SPICLK;
               cs_q[0]   <= bus.chip_select;
               mosi_q[0] <= bus.SPIMOSI;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sclk_q[i] <= sclk_q[i-1];
                  cs_q[i]   <= cs_q[i-1];
                  mosi_q[i] <= mosi_q[i-1];
               end
            end
         end

         assign sclk_s = sclk_q[SYNC_STAGES-1];
         assign cs_s   = cs_q[SYNC_STAGES-1];
         assign mosi_s = mosi_q[SYNC_STAGES-1];
      end else begin : g_nosync
         assign sclk_s = bus.SPICLK;
         assign cs_s   = bus.chip_select;
         assign mosi_s = bus.SPIMOSI;
      end
   endgenerate

   state_t      state;
   logic        sclk_d;
   logic [2:0]  bit_cnt;
   logic [7:0]  cmd_sr;
   logic [23:0] resp_sr;
   logic [4:0]  resp_cnt;
   logic        miso_q;
   logic        miso_en_q;

   logic       rise;
   logic       fall;
   logic       cs_active;
   logic [7:0] cmd_next;

   assign rise      = sclk_s & ~sclk_d;
   assign fall      = ~sclk_s & sclk_d;
   assign cs_active = ~cs_s;
   assign cmd_next  = {cmd_sr[6:0], mosi_s};

   assign bus.SPIMISO = miso_q;
   assign bus.miso_en = miso_en_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         sclk_d    <= 1'b0;
         bit_cnt   <= 3'd0;
         cmd_sr    <= 8'h00;
         resp_sr   <= 24'h0;
         resp_cnt  <= 5'd0;
         miso_q    <= 1'b0;
         miso_en_q <= 1'b0;
         cmd_byte  <= 8'h00;
         cmd_valid <= 1'b0;
         rdid_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sclk_d    <= sclk_s;
         cmd_valid <= 1'b0;
         rdid_done <= 1'b0;
         // Deselect beats any edge seen in the same cycle.
         if (state != IDLE && !cs_active) begin
            state     <= IDLE;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  miso_q    <= 1'b0;
                  miso_en_q <= 1'b0;
                  if (cs_active) begin
                     state   <= CMD;
                     busy    <= 1'b1;
                     bit_cnt <= 3'd0;
                     cmd_sr  <= 8'h00;
                  end
               end
               CMD: begin
                  if (rise) begin
                     cmd_sr  <= cmd_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        cmd_byte  <= cmd_next;
                        cmd_valid <= 1'b1;
                        if (cmd_next == RDID_CMD) begin
                           state     <= RESP;
                           resp_sr   <= ID_WORD;
                           resp_cnt  <= 5'd0;
                           miso_en_q <= 1'b1;
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end
               RESP: begin
                  if (fall) begin
                     miso_q  <= resp_sr[23];
                     resp_sr <= {resp_sr[22:0], 1'b0};
                  end else if (rise) begin
                     // Reload on the 24th sampled bit so longer reads wrap.
                     if (resp_cnt == 5'd23) begin
                        resp_cnt  <= 5'd0;
                        resp_sr   <= ID_WORD;
                        rdid_done <= 1'b1;
                     end else begin
                        resp_cnt <= resp_cnt + 5'd1;
                     end
                  end
               end
               IGNORE: begin
                  miso_q    <= 1'b0;
                  miso_en_q <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_rdid_responder.sv
// Bench for spi_rdid_responder: a default-parameter instance and an overridden
// one (EF/40/18, no synchronizer) share one SPI master running at clk/8.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_rdid_responder;

   logic clk = 1'b0;
   logic reset;
   logic sclk, cs, mosi;

   always #5 clk = ~clk;

   spi_rdid_responder_if bus0 ();
   spi_rdid_responder_if bus1 ();

   assign bus0.SPICLK      = sclk;
   assign bus0.chip_select = cs;
   assign bus0.SPIMOSI     = mosi;
   assign bus1.SPICLK      = sclk;
   assign bus1.chip_select = cs;
   assign bus1.SPIMOSI     = mosi;

   logic [7:0] cmd_byte0, cmd_byte1;
   logic       cmd_valid0, cmd_valid1, rdid_done0, rdid_done1, busy0, busy1;

   spi_rdid_responder dut0 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus0.slave),
      .cmd_byte  (cmd_byte0),
      .cmd_valid (cmd_valid0),
      .rdid_done (rdid_done0),
      .busy      (busy0)
   );

   spi_rdid_responder #(
      .MANUF_ID    (8'hEF),
      .MEM_TYPE    (8'h40),
      .MEM_CAP     (8'h18),
      .SYNC_STAGES (0)
   ) dut1 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus1.slave),
      .cmd_byte  (cmd_byte1),
      .cmd_valid (cmd_valid1),
      .rdid_done (rdid_done1),
      .busy      (busy1)
   );

   int checks = 0;
   int errors = 0;

   int nvalid0 = 0, nvalid1 = 0, nrdid0 = 0, nrdid1 = 0, nactive0 = 0, nactive1 = 0;

   always @(posedge clk) begin
      if (cmd_valid0) nvalid0++;
      if (cmd_valid1) nvalid1++;
      if (rdid_done0) nrdid0++;
      if (rdid_done1) nrdid1++;
      if (bus0.miso_en || bus0.SPIMISO) nactive0++;
      if (bus1.miso_en || bus1.SPIMISO) nactive1++;
   end

   logic [47:0] cap0, cap1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_xfer();
      cs = 1'b0;
      tick(6);
   endtask

   task automatic send_bits(input logic [7:0] val, input int nb);
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = val[i];
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
      mosi = 1'b0;
   endtask

   task automatic clock_data(input int nbits);
      for (int i = 0; i < nbits; i++) begin
         tick(4);
         cap0 = {cap0[46:0], bus0.SPIMISO};
         cap1 = {cap1[46:0], bus1.SPIMISO};
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   task automatic end_xfer();
      tick(4);
      cs = 1'b1;
      tick(6);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      int          nbits;
      logic [47:0] exp_cap0;
      logic [47:0] exp_cap1;
      int          exp_rdid;
      bit          quiet;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int v0, v1, r0, r1, a0, a1;

      vecs[0] = '{8'h9F, 24, 48'h202016,       48'hEF4018,       1, 1'b0};
      vecs[1] = '{8'h05, 24, 48'h0,            48'h0,            0, 1'b1};
      vecs[2] = '{8'h9F, 48, 48'h202016202016, 48'hEF4018EF4018, 2, 1'b0};
      vecs[3] = '{8'h9E, 16, 48'h0,            48'h0,            0, 1'b1};
      vecs[4] = '{8'h9F, 23, 48'h10100B,       48'h77A00C,       0, 1'b0};
      vecs[5] = '{8'hFF,  8, 48'h0,            48'h0,            0, 1'b1};

      reset = 1'b0;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      tick(3);
      chk("reset_outputs0", {busy0, cmd_valid0, rdid_done0, bus0.SPIMISO, bus0.miso_en, cmd_byte0},
          {5'b0, 8'h00});
      chk("reset_outputs1", {busy1, cmd_valid1, rdid_done1, bus1.SPIMISO, bus1.miso_en, cmd_byte1},
          {5'b0, 8'h00});
      reset = 1'b1;
      tick(2);

      for (int k = 0; k < 6; k++) begin
         v0 = nvalid0; v1 = nvalid1; r0 = nrdid0; r1 = nrdid1; a0 = nactive0; a1 = nactive1;
         cap0 = '0;
         cap1 = '0;
         start_xfer();
         chk($sformatf("v%0d_busy_on", k), busy0, 1'b1);
         send_bits(vecs[k].cmd, 8);
         clock_data(vecs[k].nbits);
         end_xfer();
         chk($sformatf("v%0d_cmd_byte0", k), cmd_byte0, vecs[k].cmd);
         chk($sformatf("v%0d_cmd_byte1", k), cmd_byte1, vecs[k].cmd);
         chk($sformatf("v%0d_valid0", k), nvalid0 - v0, 1);
         chk($sformatf("v%0d_valid1", k), nvalid1 - v1, 1);
         chk($sformatf("v%0d_rdid0", k), nrdid0 - r0, vecs[k].exp_rdid);
         chk($sformatf("v%0d_rdid1", k), nrdid1 - r1, vecs[k].exp_rdid);
         chk($sformatf("v%0d_cap0", k), cap0, vecs[k].exp_cap0);
         chk($sformatf("v%0d_cap1", k), cap1, vecs[k].exp_cap1);
         chk($sformatf("v%0d_busy_off", k), {busy0, busy1}, 2'b00);
         if (vecs[k].quiet) begin
            chk($sformatf("v%0d_quiet0", k), nactive0 - a0, 0);
            chk($sformatf("v%0d_quiet1", k), nactive1 - a1, 0);
         end
      end

      // Abort after four instruction bits: nothing latched, prior cmd_byte kept.
      v0 = nvalid0;
      start_xfer();
      send_bits(8'h9F, 4);
      tick(2);
      cs = 1'b1;
      tick(4);
      chk("abort_busy", {busy0, busy1}, 2'b00);
      chk("abort_cmd_byte", cmd_byte0, 8'hFF);
      chk("abort_valid", nvalid0 - v0, 0);
      tick(4);
      cap0 = '0; cap1 = '0;
      start_xfer();
      send_bits(8'h9F, 8);
      clock_data(24);
      end_xfer();
      chk("after_abort_cap0", cap0, 48'h202016);
      chk("after_abort_cap1", cap1, 48'hEF4018);

      // Reset pulse in the middle of a response.
      cap0 = '0; cap1 = '0;
      start_xfer();
      send_bits(8'h9F, 8);
      clock_data(10);
      chk("mid_resp_cap0", cap0, 48'h2020 >> 6);
      chk("mid_resp_miso_en", {bus0.miso_en, bus1.miso_en}, 2'b11);
      reset = 1'b0;
      tick(1);
      chk("rst_mid_outputs0", {busy0, cmd_valid0, rdid_done0, bus0.SPIMISO, bus0.miso_en, cmd_byte0},
          {5'b0, 8'h00});
      chk("rst_mid_outputs1", {busy1, bus1.miso_en, cmd_byte1}, {2'b0, 8'h00});
      reset = 1'b1;
      tick(4);
      cs = 1'b1;
      tick(6);
      r0 = nrdid0;
      cap0 = '0; cap1 = '0;
      start_xfer();
      send_bits(8'h9F, 8);
      clock_data(24);
      end_xfer();
      chk("after_rst_cap0", cap0, 48'h202016);
      chk("after_rst_cap1", cap1, 48'hEF4018);
      chk("after_rst_rdid0", nrdid0 - r0, 1);
      chk("after_rst_cmd_byte", cmd_byte0, 8'h9F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
